// File: rtl/wasca_led_driver_if.sv
// LED driver bus: PIO level, activity strobe and mode in; registered pin drive out.
// Combinational bundle only; no handshake, so there is no backpressure.
interface wasca_led_driver_if;
   logic       led_in;
   logic       activity;
   logic [1:0] mode;
   logic       led_out;

   modport master (output led_in, output activity, output mode, input led_out);
   modport slave  (input led_in, input activity, input mode, output led_out);
endinterface

// File: rtl/wasca_led_driver.sv
// Status LED pin driver with direct/blink/activity-stretch/heartbeat modes; 1 clk input-to-pin latency.
// No backpressure: every input is sampled each clock and the pin is always driven.
module wasca_led_driver #(
   parameter int unsigned PRESCALE      = 50000,
   parameter int unsigned BLINK_TICKS   = 250,
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned HB_UNIT       = 100,
   parameter logic        ACTIVE_LOW    = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   wasca_led_driver_if.slave  bus
);

   typedef enum logic [1:0] {PH_ON1, PH_OFF1, PH_ON2, PH_OFF2} phase_t;

   localparam int unsigned HB_OFF2_INT  = 7 * HB_UNIT;
   localparam logic [15:0] PRE_LAST     = 16'(PRESCALE - 1);
   localparam logic [15:0] BLINK_LAST   = 16'(BLINK_TICKS - 1);
   localparam logic [15:0] HB_LAST      = 16'(HB_UNIT - 1);
   localparam logic [15:0] HB_OFF2_LAST = 16'(HB_OFF2_INT) - 16'd1;
   localparam logic [15:0] STRETCH_LOAD = 16'(STRETCH_TICKS);

   logic [15:0] presc_q, presc_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic [15:0] stretch_q, stretch_d;
   phase_t      phase_q, phase_d;
   logic [1:0]  mode_q;
   logic        led_in_q;
   logic        led_out_q;

   logic        restart, act_load, tick, lit, phased_mode;
   logic [15:0] phase_last;

   always_comb begin
      // Holding the sequencers in restart while disabled makes led_in=0 win in every mode.
      restart     = ~bus.led_in | (bus.led_in & ~led_in_q) | (bus.mode != mode_q);
      act_load    = bus.led_in & bus.activity & (bus.mode == 2'd2);
      tick        = (presc_q == PRE_LAST);
      phased_mode = (bus.mode == 2'd1) | (bus.mode == 2'd3);

      presc_d = (restart | act_load | tick) ? 16'd0 : presc_q + 16'd1;

      if (phase_q == PH_OFF2)      phase_last = HB_OFF2_LAST;
      else if (bus.mode == 2'd1)   phase_last = BLINK_LAST;
      else                         phase_last = HB_LAST;

      phase_d    = phase_q;
      tick_cnt_d = tick_cnt_q;
      if (restart) begin
         phase_d    = PH_ON1;
         tick_cnt_d = 16'd0;
      end else if (tick && phased_mode) begin
         if (tick_cnt_q == phase_last) begin
            tick_cnt_d = 16'd0;
            if (bus.mode == 2'd1) begin
               phase_d = (phase_q == PH_ON1) ? PH_OFF1 : PH_ON1;
            end else begin
               case (phase_q)
                  PH_ON1:  phase_d = PH_OFF1;
                  PH_OFF1: phase_d = PH_ON2;
                  PH_ON2:  phase_d = PH_OFF2;
                  default: phase_d = PH_ON1;
               endcase
            end
         end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
         end
      end

      // A reload on the same edge as the final tick keeps the LED lit.
      stretch_d = stretch_q;
      if (act_load)
         stretch_d = STRETCH_LOAD;
      else if (restart)
         stretch_d = 16'd0;
      else if (tick && (stretch_q != 16'd0))
         stretch_d = stretch_q - 16'd1;

      case (bus.mode)
         2'd0:    lit = bus.led_in;
         2'd1:    lit = bus.led_in & (phase_d == PH_ON1);
         2'd2:    lit = bus.led_in & (stretch_d != 16'd0);
         default: lit = bus.led_in & ((phase_d == PH_ON1) | (phase_d == PH_ON2));
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q    <= 16'd0;
         tick_cnt_q <= 16'd0;
         stretch_q  <= 16'd0;
         phase_q    <= PH_ON1;
         mode_q     <= 2'd0;
         led_in_q   <= 1'b0;
         led_out_q  <= ACTIVE_LOW;
      end else begin
         presc_q    <= presc_d;
         tick_cnt_q <= tick_cnt_d;
         stretch_q  <= stretch_d;
         phase_q    <= phase_d;
         mode_q     <= bus.mode;
         led_in_q   <= bus.led_in;
         led_out_q  <= lit ^ ACTIVE_LOW;
      end
   end

   assign bus.led_out = led_out_q;

endmodule

// File: doc/wasca_led_driver.md
Name: wasca_led_driver

Overview:
- Output stage between the LED PIO register and the physical status LED pin.
- Takes the PIO's 1-bit LED level plus an activity strobe from the cartridge bus logic.
- Produces the pin drive in one of four statically selected modes: direct, blink, activity-stretch or heartbeat.
- Owns all LED timing, so firmware writes only a level bit.

Parameters:
- PRESCALE, 50000: clocks per tick (1 ms at 50 MHz); legal range 2..65535.
- BLINK_TICKS, 250: ticks per blink half-period; legal range 1..65535.
- STRETCH_TICKS, 50: ticks the LED is held on after the last activity pulse; legal range 1..65535.
- HB_UNIT, 100: heartbeat time unit in ticks; legal range 1..8191.
- ACTIVE_LOW, 1: 1 = led_out is inverted at the pin (0 drives the LED on).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- led_in  in  1  LED enable level from the PIO output register
- activity  in  1  single-cycle activity strobe, synchronous to clk
- mode  in  2  0 direct, 1 blink, 2 activity, 3 heartbeat; quasi-static
- led_out  out  1  registered pin drive

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset state:
  - Logical LED is off, so led_out = ACTIVE_LOW (pin off).
  - Prescaler, tick counter and phase state are cleared.
  - mode_q and led_in_q are cleared to 0.
- Registered output: all outputs are registered. The logical LED value lit is computed each cycle, and led_out <= lit ^ ACTIVE_LOW. Latency is 1 clk from any input change to led_out.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps; tick is a 1-clk pulse when the count equals PRESCALE-1.
  - Restart event: led_in rising (vs. led_in_q), a change of mode (vs. mode_q), or exit from reset.
  - On a restart, the prescaler and tick counter clear in the same cycle. The first tick therefore falls exactly PRESCALE clocks after the restart.
- Tick counter: 16 bits. It counts ticks within the current phase and clears on every phase change.
- led_in = 0 has priority in every mode:
  - lit = 0 on the next edge.
  - Phase state returns to its initial state.
  - Activity pulses are ignored.
- Mode 0, direct: lit = led_in.
- Mode 1, blink: states ON and OFF.
  - A restart with led_in = 1 enters ON.
  - Each state lasts BLINK_TICKS ticks, then toggles; the sequence wraps forever.
- Mode 2, activity:
  - activity with led_in = 1 sets lit = 1, loads the stretch counter with STRETCH_TICKS, and clears the prescaler.
  - Each tick decrements the stretch counter; lit = 0 when it reaches 0.
  - A retrigger while lit reloads the counter (extends, no glitch).
  - If activity coincides with the final tick, the reload wins.
- Mode 3, heartbeat: states HB_ON1 → HB_OFF1 → HB_ON2 → HB_OFF2 → HB_ON1.
  - Durations are 1, 1, 1 and 7 HB_UNIT ticks respectively.
  - HB_OFF2's end count is 7*HB_UNIT computed in 16 bits.
  - A restart enters HB_ON1.
- Mode change mid-phase: counters restart and the new mode enters its initial state (ON / HB_ON1 / stretch counter idle) on the next edge.
- Reset asserted mid-operation: outputs go to the reset state immediately, with no clock required.

Test Plan:
All scenarios use PRESCALE=4, BLINK_TICKS=3, STRETCH_TICKS=5, HB_UNIT=2, ACTIVE_LOW=0.
- Reset and direct mode:
  - Stimulus: assert reset_n=0 with led_in=1; then release with mode=0.
  - Response: led_out=0 during reset; led_out=1 one clk after release. Drop led_in → led_out=0 one clk later.
- Blink:
  - Stimulus: mode=1; led_in rises and is sampled at edge E0.
  - Response: led_out=1 from E0+1; 0 at E0+13; 1 at E0+25. Period is 24 clks, steady over 10 periods.
- Activity stretch:
  - Stimulus: mode=2, led_in=1; activity pulse at edge E0.
  - Response: led_out=1 from E0+1 to E0+21.
  - Stimulus: second pulse at E0+10.
  - Response: the on interval extends to E0+31. A pulse with led_in=0 produces no output.
- Heartbeat:
  - Stimulus: mode=3, led_in rise at E0.
  - Response: on 8 clks, off 8, on 8, off 56; repeats with an 80-clk period.
- Mode change and gating:
  - Stimulus: switch 1→3 mid-OFF phase.
  - Response: HB_ON1 starts the next edge.
  - Stimulus: led_in=0 during HB_ON2.
  - Response: led_out=0 next edge. Re-enable → sequence restarts at HB_ON1.
- Polarity and async reset:
  - Stimulus: ACTIVE_LOW=1 build.
  - Response: led_out=1 in reset and idle.
  - Stimulus: reset_n pulse mid-blink, between clock edges.
  - Response: led_out returns to the reset level immediately.
